// File: rtl/pwm_pkg.sv
// pwm_pkg: state encodings, range codes and the ramp-direction helper shared by the fan-drive stage.
package pwm_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    UP    = 3'd2,
    DOWN  = 3'd3,
    ALARM = 3'd4
  } estado_t;
  localparam logic [1:0] R_BAJO    = 2'd0;
  localparam logic [1:0] R_MEDIO   = 2'd1;
  localparam logic [1:0] R_ALTO    = 2'd2;
  localparam logic [1:0] R_CRITICO = 2'd3;
  function automatic estado_t dir_de(input logic [7:0] tgt, input logic [7:0] cur);
    return tgt > cur ? UP : tgt < cur ? DOWN : HOLD;
  endfunction
endpackage

// File: rtl/pwm_contador.sv
// pwm_contador: free-running 8-bit period counter and duty comparator with a registered PWM output.
module pwm_contador (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] duty,
  output logic       pwm,
  output logic       fin_periodo
);
  logic [7:0] r_cnt;
  logic       r_pwm;
  assign fin_periodo = en & (r_cnt == 8'hFF);
  assign pwm = r_pwm;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= en ? r_cnt + 8'd1 : 8'd0;
      r_pwm <= en & ((duty == 8'hFF) | (r_cnt < duty));
    end
  end
endmodule

// File: rtl/pwm_ventilador.sv
// pwm_ventilador: fan PWM stage; ramps duty toward a per-range target at period boundaries and
// forces full speed after repeated critical-range samples.
module pwm_ventilador
  import pwm_pkg::*;
#(
  parameter logic [7:0] DUTY_R0  = 8'd0,
  parameter logic [7:0] DUTY_R1  = 8'd64,
  parameter logic [7:0] DUTY_R2  = 8'd160,
  parameter logic [7:0] DUTY_R3  = 8'd255,
  parameter int         STEP     = 8,
  parameter int         RAMP_DIV = 4,
  parameter int         ALARM_N  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] rango,
  input  logic       rango_valid,
  output logic       pwm,
  output logic [7:0] duty,
  output logic [2:0] estado,
  output logic       alarma
);
  localparam int              AW       = $clog2(ALARM_N + 1);
  localparam logic [AW-1:0]   A_MAX    = AW'(ALARM_N);
  localparam logic [7:0]      DIV_LAST = 8'(RAMP_DIV - 1);
  localparam logic [8:0]      STEP9    = 9'(STEP);
  estado_t       r_estado;
  logic [7:0]    r_duty, r_target, r_div;
  logic [AW-1:0] r_acnt;
  logic          r_alarma;
  logic          w_fin, w_step, w_sample, w_crit;
  logic [7:0]    w_tgt_new, w_next;
  logic [8:0]    w_up, w_dn;
  pwm_contador u_contador (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .duty       (r_duty),
    .pwm        (pwm),
    .fin_periodo(w_fin)
  );
  // Ramp arithmetic is 9-bit so an overshoot or underflow shows up before clamping to the target.
  always_comb begin
    w_sample  = rango_valid & en;
    w_crit    = rango == R_CRITICO;
    w_tgt_new = rango == R_BAJO ? DUTY_R0 : rango == R_MEDIO ? DUTY_R1 : rango == R_ALTO ? DUTY_R2 : DUTY_R3;
    w_step    = w_fin & (r_div == DIV_LAST);
    w_up      = {1'b0, r_duty} + STEP9;
    w_dn      = {1'b0, r_duty} - STEP9;
    w_next    = r_target > r_duty ? (w_up > {1'b0, r_target} ? r_target : w_up[7:0])
              : r_target < r_duty ? ((w_dn[8] | (w_dn[7:0] < r_target)) ? r_target : w_dn[7:0])
              : r_duty;
  end
  // The step reads r_target before a same-cycle sample overwrites it, so a colliding strobe waits a step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado <= IDLE;
      r_duty   <= '0;
      r_target <= '0;
      r_div    <= '0;
      r_acnt   <= '0;
      r_alarma <= 1'b0;
    end else if (!en) begin
      r_estado <= IDLE;
      r_duty   <= '0;
      r_div    <= '0;
      r_acnt   <= '0;
      r_alarma <= 1'b0;
    end else begin
      if (w_sample) begin
        r_target <= w_tgt_new;
        r_acnt   <= !w_crit ? '0 : (r_acnt == A_MAX ? r_acnt : r_acnt + 1'b1);
      end
      if (w_fin) r_div <= (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;
      if (r_estado == IDLE) r_estado <= dir_de(r_target, r_duty);
      else if (r_estado == ALARM) begin
        if (w_fin) r_duty <= 8'hFF;
        if (w_sample && !w_crit) begin
          r_estado <= DOWN;
          r_alarma <= 1'b0;
        end
      end else if (r_acnt == A_MAX) begin
        r_estado <= ALARM;
        r_alarma <= 1'b1;
      end else if (w_step && r_estado != HOLD) begin
        r_duty   <= w_next;
        r_estado <= dir_de(r_target, w_next);
      end else r_estado <= dir_de(r_target, r_duty);
    end
  end
  assign duty   = r_duty;
  assign estado = r_estado;
  assign alarma = r_alarma;
endmodule

// File: tb/tb_pwm_ventilador.sv
// tb_pwm_ventilador: directed ramp vectors on STEP=8 and STEP=48 instances plus alarm, enable-drop,
// collision and asynchronous-reset sequences.
module tb_pwm_ventilador;
  import pwm_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_a = 1'b1, rst_b = 1'b1, en_a, en_b, valid, sel;
  logic [1:0] rango;
  logic       pwm_a, pwm_b, alarma_a, alarma_b;
  logic [7:0] duty_a, duty_b;
  logic [2:0] estado_a, estado_b;
  logic       m_pwm, m_alarma;
  logic [7:0] m_duty;
  logic [2:0] m_estado;
  int checks = 0, errors = 0;
  assign m_pwm    = sel ? pwm_b : pwm_a;
  assign m_alarma = sel ? alarma_b : alarma_a;
  assign m_duty   = sel ? duty_b : duty_a;
  assign m_estado = sel ? estado_b : estado_a;
  pwm_ventilador u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .rango(rango), .rango_valid(valid & ~sel),
    .pwm(pwm_a), .duty(duty_a), .estado(estado_a), .alarma(alarma_a)
  );
  pwm_ventilador #(.STEP(48)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .rango(rango), .rango_valid(valid & sel),
    .pwm(pwm_b), .duty(duty_b), .estado(estado_b), .alarma(alarma_b)
  );
  typedef struct {
    logic       sel;
    logic [1:0] rango;
    estado_t    dir;
    int         fin;
    int         st;
    int         n;
  } vec_t;
  vec_t tv [6];
  int cur [2];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic strobe(input logic [1:0] r);
    rango = r;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask
  task automatic wait_change(input logic [7:0] old, input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_duty == old && n < lim);
  endtask
  initial begin
    int e, n, hi, s;
    tv[0] = '{1'b0, R_ALTO,  UP,   160, 8,  20};
    tv[1] = '{1'b0, R_MEDIO, DOWN, 64,  8,  12};
    tv[2] = '{1'b0, R_BAJO,  DOWN, 0,   8,  8};
    tv[3] = '{1'b1, R_MEDIO, UP,   64,  48, 2};
    tv[4] = '{1'b1, R_BAJO,  DOWN, 0,   48, 2};
    tv[5] = '{1'b1, R_ALTO,  UP,   160, 48, 4};
    cur[0] = 0;
    cur[1] = 0;
    sel = 1'b0; valid = 1'b0; rango = 2'd0; en_a = 1'b0; en_b = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    tick(2);
    chk("reset pwm", m_pwm, 0);
    chk("reset duty", m_duty, 0);
    chk("reset estado", m_estado, IDLE);
    chk("reset alarma", m_alarma, 0);
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    tick(2);
    chk("enable hold", m_estado, HOLD);
    for (int i = 0; i < 6; i++) begin
      sel = tv[i].sel;
      s = int'(tv[i].sel);
      strobe(tv[i].rango);
      tick(1);
      chk($sformatf("v%0d direction", i), m_estado, tv[i].dir);
      for (int k = 0; k < tv[i].n; k++) begin
        e = tv[i].dir == UP ? ((cur[s] + tv[i].st > tv[i].fin) ? tv[i].fin : cur[s] + tv[i].st)
                            : ((cur[s] - tv[i].st < tv[i].fin) ? tv[i].fin : cur[s] - tv[i].st);
        wait_change(8'(cur[s]), 1400, n);
        chk($sformatf("v%0d step%0d duty", i, k), m_duty, e);
        if (k > 0) chk($sformatf("v%0d step%0d interval", i, k), n, 1024);
        cur[s] = e;
      end
      chk($sformatf("v%0d final duty", i), m_duty, tv[i].fin);
      chk($sformatf("v%0d hold", i), m_estado, HOLD);
      hi = 0;
      repeat (256) begin
        @(negedge clk);
        hi += int'(m_pwm);
      end
      chk($sformatf("v%0d pwm high count", i), hi, tv[i].fin);
    end
    // asynchronous reset on the STEP=48 instance sitting at duty 160
    n = 0;
    while (m_pwm !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("pre-reset pwm", m_pwm, 1);
    chk("pre-reset duty", m_duty, 160);
    #2 rst_b = 1'b0;
    #1;
    chk("async reset pwm", m_pwm, 0);
    chk("async reset duty", m_duty, 0);
    chk("async reset estado", m_estado, IDLE);
    chk("async reset alarma", m_alarma, 0);
    @(negedge clk);
    rst_b = 1'b1;
    sel = 1'b0;
    // alarm raise, forced full speed and release
    strobe(R_CRITICO);
    strobe(R_CRITICO);
    chk("alarm after two", m_alarma, 0);
    strobe(R_CRITICO);
    chk("alarm third sample edge", m_alarma, 0);
    tick(1);
    chk("alarma raised", m_alarma, 1);
    chk("estado alarm", m_estado, ALARM);
    n = 0;
    while (m_duty != 8'hFF && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("alarm duty full", m_duty, 255);
    tick(1);
    hi = 0;
    repeat (300) begin
      hi += int'(m_pwm);
      @(negedge clk);
    end
    chk("alarm pwm constant high", hi, 300);
    chk("estado still alarm", m_estado, ALARM);
    strobe(R_MEDIO);
    chk("alarm release", m_alarma, 0);
    chk("alarm release down", m_estado, DOWN);
    wait_change(8'hFF, 1400, n);
    chk("first step down from alarm", m_duty, 247);
    // interrupted critical run restarts the counter
    strobe(R_CRITICO);
    strobe(R_CRITICO);
    strobe(R_ALTO);
    strobe(R_CRITICO);
    tick(3);
    chk("interrupted alarma", m_alarma, 0);
    chk("interrupted not alarm", m_estado == ALARM, 0);
    strobe(R_CRITICO);
    tick(2);
    chk("restart count two", m_alarma, 0);
    strobe(R_CRITICO);
    tick(1);
    chk("restart count three", m_alarma, 1);
    // enable drop clears alarm, duty and pwm; target is retained
    en_a = 1'b0;
    tick(1);
    chk("en drop estado", m_estado, IDLE);
    chk("en drop duty", m_duty, 0);
    chk("en drop pwm", m_pwm, 0);
    chk("en drop alarma", m_alarma, 0);
    tick(3);
    en_a = 1'b1;
    wait_change(8'd0, 1400, n);
    chk("re-enable first step cycles", n, 1024);
    chk("re-enable first step duty", m_duty, 8);
    chk("re-enable retained target up", m_estado, UP);
    tick(2);
    chk("pwm high before drop", m_pwm, 1);
    en_a = 1'b0;
    tick(1);
    chk("drop during up estado", m_estado, IDLE);
    chk("drop during up duty", m_duty, 0);
    chk("drop during up pwm", m_pwm, 0);
    // strobe lands on the step boundary: the step still heads to the old target
    tick(2);
    en_a = 1'b1;
    tick(1023);
    rango = R_BAJO;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    chk("collision uses old target", m_duty, 8);
    tick(1);
    chk("collision then down", m_estado, DOWN);
    wait_change(8'd8, 1400, n);
    chk("collision next step cycles", n, 1023);
    chk("collision next step duty", m_duty, 0);
    chk("collision hold", m_estado, HOLD);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
